// File: rtl/text_banner.sv
// text_banner: on-screen text overlay for race messages (FINISH, GO!, PAUSED,
// LAP n). Places the latched message at (X0,Y0), magnified by 2^SCALE_LOG2,
// drives an external synchronous 8x16 font ROM and returns a text pixel flag
// aligned 3 clocks after pix_x/pix_y. Optional per-character reveal and blink.
//
// Ports:
//   clk        pixel clock
//   rst_n      asynchronous active-low reset
//   frame_tick one-cycle pulse per frame (vsync start)
//   enable     banner requested (level)
//   msg_sel    0=FINISH 1=GO! 2=PAUSED 3=LAP n
//   lap_num    digit shown for LAP n (>9 shows '?')
//   reveal_en  reveal one character at a time
//   blink_en   blink once fully shown
//   pix_x/y    current pixel column/row
//   rom_addr   {char[6:0], row[3:0]} to font ROM, registered
//   rom_data   font ROM row, valid one cycle after rom_addr
//   text_on    banner pixel lit, registered
//   active     FSM not idle
module text_banner #(
  parameter int X0            = 128,
  parameter int Y0            = 128,
  parameter int SCALE_LOG2    = 3,
  parameter int REVEAL_FRAMES = 8,
  parameter int BLINK_FRAMES  = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic [1:0]  msg_sel,
  input  logic [3:0]  lap_num,
  input  logic        reveal_en,
  input  logic        blink_en,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        text_on,
  output logic        active
);

  localparam int MAXF = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
  localparam int FW   = (MAXF > 1) ? $clog2(MAXF) : 1;

  localparam logic [FW-1:0] REVEAL_LAST = FW'(REVEAL_FRAMES - 1);
  localparam logic [FW-1:0] BLINK_LAST  = FW'(BLINK_FRAMES - 1);

  // Geometry is compared in 12 bits so the box edge never wraps in 10 bits.
  localparam logic [11:0] X0_W   = 12'(X0);
  localparam logic [11:0] Y0_W   = 12'(Y0);
  localparam logic [11:0] Y_SPAN = 12'(16 << SCALE_LOG2);
  localparam logic [9:0]  X0_10  = 10'(X0);
  localparam logic [9:0]  Y0_10  = 10'(Y0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    SHOW   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [FW-1:0] frame_cnt, frame_n;
  logic [2:0]    reveal_cnt, reveal_n;
  logic          vis, vis_n;
  logic [1:0]    msg_q, msg_n;
  logic [3:0]    lap_q, lap_n;
  logic          en_q;
  logic          rise;

  function automatic logic [2:0] msg_len(input logic [1:0] m);
    case (m)
      2'd0:    msg_len = 3'd6;
      2'd1:    msg_len = 3'd3;
      2'd2:    msg_len = 3'd6;
      default: msg_len = 3'd5;
    endcase
  endfunction

  function automatic logic [6:0] msg_char(input logic [1:0] m, input logic [2:0] idx,
                                          input logic [3:0] lap);
    logic [6:0] c;
    c = 7'h00;
    case (m)
      2'd0: case (idx)
        3'd0: c = 7'h46;
        3'd1: c = 7'h49;
        3'd2: c = 7'h4E;
        3'd3: c = 7'h49;
        3'd4: c = 7'h53;
        3'd5: c = 7'h48;
        default: c = 7'h00;
      endcase
      2'd1: case (idx)
        3'd0: c = 7'h47;
        3'd1: c = 7'h4F;
        3'd2: c = 7'h21;
        default: c = 7'h00;
      endcase
      2'd2: case (idx)
        3'd0: c = 7'h50;
        3'd1: c = 7'h41;
        3'd2: c = 7'h55;
        3'd3: c = 7'h53;
        3'd4: c = 7'h45;
        3'd5: c = 7'h44;
        default: c = 7'h00;
      endcase
      default: case (idx)
        3'd0: c = 7'h4C;
        3'd1: c = 7'h41;
        3'd2: c = 7'h50;
        3'd3: c = 7'h20;
        3'd4: c = (lap <= 4'd9) ? (7'h30 + {3'b000, lap}) : 7'h3F;
        default: c = 7'h00;
      endcase
    endcase
    return c;
  endfunction

  assign rise   = enable & ~en_q;
  assign active = (state != IDLE);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      reveal_cnt <= '0;
      vis        <= 1'b1;
      msg_q      <= '0;
      lap_q      <= '0;
      en_q       <= 1'b0;
    end else begin
      state      <= state_n;
      frame_cnt  <= frame_n;
      reveal_cnt <= reveal_n;
      vis        <= vis_n;
      msg_q      <= msg_n;
      lap_q      <= lap_n;
      en_q       <= enable;
    end
  end

  always_comb begin
    state_n  = state;
    frame_n  = frame_cnt;
    reveal_n = reveal_cnt;
    vis_n    = vis;
    msg_n    = msg_q;
    lap_n    = lap_q;
    if (!enable) begin
      state_n  = IDLE;
      frame_n  = '0;
      reveal_n = '0;
      vis_n    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // A frame_tick coinciding with the rise is deliberately not counted.
          if (rise) begin
            msg_n   = msg_sel;
            lap_n   = lap_num;
            frame_n = '0;
            vis_n   = 1'b1;
            if (reveal_en) begin
              state_n  = REVEAL;
              reveal_n = 3'd1;
            end else begin
              state_n  = SHOW;
              reveal_n = msg_len(msg_sel);
            end
          end
        end
        REVEAL: begin
          if (reveal_cnt >= msg_len(msg_q)) begin
            state_n = SHOW;
            frame_n = '0;
            vis_n   = 1'b1;
          end else if (frame_tick) begin
            if (frame_cnt == REVEAL_LAST) begin
              frame_n  = '0;
              reveal_n = reveal_cnt + 3'd1;
              if (reveal_cnt + 3'd1 == msg_len(msg_q)) begin
                state_n = SHOW;
                vis_n   = 1'b1;
              end
            end else begin
              frame_n = frame_cnt + 1'b1;
            end
          end
        end
        SHOW: begin
          if (!blink_en) begin
            vis_n   = 1'b1;
            frame_n = '0;
          end else if (frame_tick) begin
            if (frame_cnt == BLINK_LAST) begin
              frame_n = '0;
              vis_n   = ~vis;
            end else begin
              frame_n = frame_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // ---------------- geometry ----------------
  logic [11:0] px_w, py_w, x_span;
  logic        in_box;
  logic [9:0]  dx, dy, char_full, col_full, row_full;
  logic [2:0]  char_idx, col;
  logic [3:0]  row;
  logic        lit;
  logic        unused_geom;

  always_comb begin
    px_w      = {2'b00, pix_x};
    py_w      = {2'b00, pix_y};
    x_span    = {9'd0, msg_len(msg_q)} << (SCALE_LOG2 + 3);
    in_box    = (px_w >= X0_W) && (px_w < X0_W + x_span) &&
                (py_w >= Y0_W) && (py_w < Y0_W + Y_SPAN);
    dx        = pix_x - X0_10;
    dy        = pix_y - Y0_10;
    char_full = dx >> (SCALE_LOG2 + 3);
    col_full  = dx >> SCALE_LOG2;
    row_full  = dy >> SCALE_LOG2;
    char_idx  = char_full[2:0];
    col       = col_full[2:0];
    row       = row_full[3:0];
    lit       = in_box & active & vis & (char_full < {7'd0, reveal_cnt});
  end

  assign unused_geom = ^{col_full[9:3], row_full[9:4]};

  // ---------------- pixel pipeline ----------------
  logic [2:0] col_q, col_d;
  logic       lit_q, lit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      col_q    <= '0;
      lit_q    <= 1'b0;
      col_d    <= '0;
      lit_d    <= 1'b0;
      text_on  <= 1'b0;
    end else begin
      rom_addr <= lit ? {msg_char(msg_q, char_idx, lap_q), row} : {7'h00, row};
      col_q    <= col;
      lit_q    <= lit;
      col_d    <= col_q;
      lit_d    <= lit_q;
      text_on  <= lit_d & rom_data[3'd7 - col_d];
    end
  end

endmodule

// File: tb/tb_text_banner.sv
// Scoreboard bench for text_banner: each pixel probe pushes its expected
// rom_addr (due +1 clk) and text_on (due +3 clk); a negedge monitor pops and
// compares. The font ROM is a simple synchronous function of the address.
module tb_text_banner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  msg_sel = '0;
  logic [3:0]  lap_num = '0;
  logic        reveal_en = 1'b0;
  logic        blink_en = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        text_on;
  logic        active;

  always #5 clk = ~clk;

  text_banner #(
    .X0(128), .Y0(128), .SCALE_LOG2(3), .REVEAL_FRAMES(2), .BLINK_FRAMES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .msg_sel(msg_sel), .lap_num(lap_num), .reveal_en(reveal_en),
    .blink_en(blink_en), .pix_x(pix_x), .pix_y(pix_y), .rom_addr(rom_addr),
    .rom_data(rom_data), .text_on(text_on), .active(active)
  );

  function automatic logic [7:0] font(input logic [10:0] a);
    return a[7:0] ^ a[10:3];
  endfunction

  always @(posedge clk) rom_data <= font(rom_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int          a_due[$];
  logic [10:0] a_exp[$];
  int          a_id[$];
  int          t_due[$];
  logic        t_exp[$];
  int          t_id[$];

  always @(negedge clk) begin : monitor
    int due, id;
    logic [10:0] ea;
    logic et;
    if (rst_n) begin
      while (a_due.size() > 0 && a_due[0] <= cyc) begin
        due = a_due.pop_front(); ea = a_exp.pop_front(); id = a_id.pop_front();
        checks++;
        if (due < cyc) begin
          errors++; $display("FAIL rom_addr probe %0d: missed due cycle %0d", id, due);
        end else if (rom_addr !== ea) begin
          errors++; $display("FAIL rom_addr probe %0d: got %03h expected %03h", id, rom_addr, ea);
        end
      end
      while (t_due.size() > 0 && t_due[0] <= cyc) begin
        due = t_due.pop_front(); et = t_exp.pop_front(); id = t_id.pop_front();
        checks++;
        if (due < cyc) begin
          errors++; $display("FAIL text_on probe %0d: missed due cycle %0d", id, due);
        end else if (text_on !== et) begin
          errors++; $display("FAIL text_on probe %0d: got %b expected %b", id, text_on, et);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic probe(input int x, input int y, input logic [10:0] ea,
                       input logic elit, input logic [2:0] col, input int id);
    logic [7:0] f;
    @(posedge clk); #1;
    pix_x = 10'(x);
    pix_y = 10'(y);
    f = font(ea);
    a_due.push_back(cyc + 1); a_exp.push_back(ea); a_id.push_back(id);
    t_due.push_back(cyc + 3); t_exp.push_back(elit & f[3'd7 - col]); t_id.push_back(id);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (a_due.size() > 0 || t_due.size() > 0); i++) @(posedge clk);
    if (a_due.size() > 0 || t_due.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d/%0d expectations still pending", a_due.size(), t_due.size());
      a_due.delete(); a_exp.delete(); a_id.delete();
      t_due.delete(); t_exp.delete(); t_id.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset rom_addr", 32'(rom_addr), 0);
    chk("reset text_on", 32'(text_on), 0);
    chk("reset active", 32'(active), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post-reset active", 32'(active), 0);
    chk("post-reset text_on", 32'(text_on), 0);

    // FINISH, no effects
    msg_sel = 2'd0; reveal_en = 1'b0; blink_en = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1;
    chk("finish active", 32'(active), 1);
    probe(128, 128, 11'h460, 1'b1, 3'd0, 1);
    probe(191, 128, 11'h460, 1'b1, 3'd7, 2);
    probe(192, 128, 11'h490, 1'b1, 3'd0, 3);
    probe(512, 128, 11'h000, 1'b0, 3'd0, 4);
    probe(511, 128, 11'h480, 1'b1, 3'd7, 5);
    probe(128, 127, 11'h00F, 1'b0, 3'd0, 6);
    probe(130, 171, 11'h465, 1'b1, 3'd0, 7);
    probe(200, 255, 11'h49F, 1'b1, 3'd1, 8);
    probe(200, 256, 11'h000, 1'b0, 3'd0, 9);
    probe(127, 128, 11'h000, 1'b0, 3'd0, 10);
    drain();

    // Asynchronous reset while a lit pixel is being shown
    pix_x = 10'd128; pix_y = 10'd128;
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset text_on", 32'(text_on), 1);
    chk("pre-reset rom_addr", 32'(rom_addr), 32'h460);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset text_on", 32'(text_on), 0);
    chk("async reset rom_addr", 32'(rom_addr), 0);
    chk("async reset active", 32'(active), 0);
    enable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("after release active", 32'(active), 0);
    chk("after release text_on", 32'(text_on), 0);

    // Reveal GO!, enable rise coinciding with a frame_tick
    msg_sel = 2'd1; reveal_en = 1'b1; blink_en = 1'b1;
    @(posedge clk); #1 enable = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    chk("reveal active", 32'(active), 1);
    probe(128, 128, 11'h470, 1'b1, 3'd0, 20);
    probe(192, 128, 11'h000, 1'b0, 3'd0, 21);
    probe(256, 128, 11'h000, 1'b0, 3'd0, 22);
    tick_n(1);
    probe(192, 128, 11'h000, 1'b0, 3'd0, 23);
    tick_n(1);
    probe(192, 128, 11'h4F0, 1'b1, 3'd0, 24);
    probe(256, 128, 11'h000, 1'b0, 3'd0, 25);
    tick_n(2);
    probe(256, 128, 11'h210, 1'b1, 3'd0, 26);
    probe(320, 128, 11'h000, 1'b0, 3'd0, 27);
    drain();
    chk("show active", 32'(active), 1);

    // Blink in SHOW
    tick_n(2);
    probe(128, 128, 11'h470, 1'b1, 3'd0, 30);
    tick_n(1);
    probe(128, 128, 11'h000, 1'b0, 3'd0, 31);
    tick_n(2);
    probe(128, 128, 11'h000, 1'b0, 3'd0, 32);
    tick_n(1);
    probe(128, 128, 11'h470, 1'b1, 3'd0, 33);
    tick_n(3);
    probe(128, 128, 11'h000, 1'b0, 3'd0, 34);
    drain();
    blink_en = 1'b0;
    probe(128, 128, 11'h470, 1'b1, 3'd0, 35);
    drain();

    // LAP 7 then LAP 12
    enable = 1'b0;
    @(posedge clk); #1;
    chk("lap idle active", 32'(active), 0);
    msg_sel = 2'd3; lap_num = 4'd7; reveal_en = 1'b0; enable = 1'b1;
    probe(128, 128, 11'h4C0, 1'b1, 3'd0, 40);
    probe(320, 128, 11'h200, 1'b1, 3'd0, 41);
    probe(384, 128, 11'h370, 1'b1, 3'd0, 42);
    probe(447, 128, 11'h370, 1'b1, 3'd7, 43);
    probe(448, 128, 11'h000, 1'b0, 3'd0, 44);
    drain();
    enable = 1'b0;
    @(posedge clk); #1 lap_num = 4'd12; enable = 1'b1;
    probe(384, 128, 11'h3F0, 1'b1, 3'd0, 45);
    drain();

    // Abort mid-reveal, ignore msg_sel change, relatch PAUSED
    enable = 1'b0;
    @(posedge clk); #1 msg_sel = 2'd0; reveal_en = 1'b1; enable = 1'b1;
    probe(128, 128, 11'h460, 1'b1, 3'd0, 50);
    probe(192, 128, 11'h000, 1'b0, 3'd0, 51);
    @(posedge clk); #1 msg_sel = 2'd2;
    tick_n(2);
    probe(128, 128, 11'h460, 1'b1, 3'd0, 52);
    probe(192, 128, 11'h490, 1'b1, 3'd0, 53);
    drain();
    enable = 1'b0;
    @(posedge clk); #1;
    chk("abort active", 32'(active), 0);
    enable = 1'b1;
    @(posedge clk); #1;
    chk("relatch active", 32'(active), 1);
    probe(128, 128, 11'h500, 1'b1, 3'd0, 54);
    probe(192, 128, 11'h000, 1'b0, 3'd0, 55);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
